// File: rtl/noc_inj_pkg.sv
// noc_inj_pkg: shared word layout, mode codes, FSM states and LFSR step
// for the NoC traffic injector.
package noc_inj_pkg;

    localparam int NODE_W  = 4;
    localparam int WORD_W  = 20;
    localparam int SEQ_LSB = 16;
    localparam int SRC_LSB = 12;
    localparam int RSV_LSB = 8;
    localparam int DST_LSB = 4;
    localparam int PLD_LSB = 0;

    localparam logic [1:0] MODE_SWEEP  = 2'd0;
    localparam logic [1:0] MODE_FIXED  = 2'd1;
    localparam logic [1:0] MODE_RANDOM = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_DONE
    } state_t;

    // x^8 + x^6 + x^5 + x^4 + 1, shifting toward the MSB
    function automatic logic [7:0] lfsr_step(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    function automatic logic [WORD_W-1:0] make_word(
        input logic [NODE_W-1:0] seq,
        input logic [NODE_W-1:0] src,
        input logic [NODE_W-1:0] dst
    );
        logic [WORD_W-1:0] w;
        w = '0;
        w[SEQ_LSB +: NODE_W] = seq;
        w[SRC_LSB +: NODE_W] = src;
        w[RSV_LSB +: NODE_W] = '0;
        w[DST_LSB +: NODE_W] = dst;
        w[PLD_LSB +: NODE_W] = dst;
        return w;
    endfunction

endpackage

// File: rtl/noc_inj_lfsr.sv
// noc_inj_lfsr: 8-bit Fibonacci LFSR for random destinations.
// Advances once per strobe; reset reloads SEED.
module noc_inj_lfsr
    import noc_inj_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       adv,
    output logic [7:0] state
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= SEED;
        end else if (adv) begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/noc_inj_gen.sv
// noc_inj_gen: per-node NoC traffic injector (sweep / fixed / random).
// Define NOC_INJ_STATS_EN to add the sent_cnt and stall_cnt counters.
module noc_inj_gen
    import noc_inj_pkg::*;
#(
    parameter int unsigned SRC_ID    = 0,
    parameter int unsigned NUM_NODES = 16,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [3:0]        fixed_dest,
    input  logic [7:0]        burst_len,
    input  logic [3:0]        gap,
    input  logic              out_ready,
    output logic [WORD_W-1:0] dataout,
    output logic              out_valid,
    output logic              busy,
    output logic              done
`ifdef NOC_INJ_STATS_EN
    ,
    output logic [15:0]       sent_cnt,
    output logic [15:0]       stall_cnt
`endif
);

    localparam logic [NODE_W:0]   NN   = NUM_NODES[NODE_W:0];
    localparam logic [NODE_W-1:0] SRC  = SRC_ID[NODE_W-1:0];
    localparam logic [NODE_W:0]   LST5 = NN - 1'b1;
    localparam logic [NODE_W-1:0] LAST = LST5[NODE_W-1:0];

    function automatic logic [NODE_W-1:0] wrap_inc(
        input logic [NODE_W-1:0] d
    );
        logic [NODE_W:0] n;
        n = {1'b0, d} + 1'b1;
        if (n >= NN) n = '0;
        return n[NODE_W-1:0];
    endfunction

    localparam logic [NODE_W-1:0] ALT = wrap_inc(SRC);

    function automatic logic [NODE_W-1:0] pick_dest(
        input logic [1:0]        m,
        input logic [NODE_W-1:0] fd,
        input logic [7:0]        l,
        input logic [NODE_W-1:0] cur
    );
        logic [NODE_W:0]   r;
        logic [NODE_W-1:0] d;
        r = {1'b0, l[NODE_W-1:0]} % NN;
        d = wrap_inc(cur);
        case (m)
            MODE_FIXED: begin
                d = (fd == SRC || {1'b0, fd} >= NN) ? ALT : fd;
            end
            MODE_RANDOM: begin
                d = (r[NODE_W-1:0] == SRC) ? ALT : r[NODE_W-1:0];
            end
            default: begin
                if (d == SRC) d = wrap_inc(d);
            end
        endcase
        return d;
    endfunction

    state_t            state;
    logic [1:0]        mode_q;
    logic [3:0]        fix_q;
    logic [7:0]        burst_q;
    logic [3:0]        gap_q;
    logic [3:0]        gcnt;
    logic [7:0]        cnt;
    logic [NODE_W-1:0] dest_q;
    logic [7:0]        lfsr_q;
    logic              accept;
    logic [7:0]        cnt_n;
    logic [NODE_W-1:0] d_first;
    logic [NODE_W-1:0] d_next;

    assign accept  = out_valid & out_ready;
    assign cnt_n   = cnt + 8'd1;
    // Sweep starts from LAST so its successor is the lowest non-self node
    assign d_first = pick_dest(mode, fixed_dest, lfsr_q, LAST);
    assign d_next  = pick_dest(mode_q, fix_q, lfsr_step(lfsr_q), dest_q);

    noc_inj_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .adv   (accept),
        .state (lfsr_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            mode_q    <= MODE_SWEEP;
            fix_q     <= '0;
            burst_q   <= '0;
            gap_q     <= '0;
            gcnt      <= '0;
            cnt       <= '0;
            dest_q    <= '0;
            dataout   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (enable) begin
                        mode_q    <= mode;
                        fix_q     <= fixed_dest;
                        burst_q   <= burst_len;
                        gap_q     <= gap;
                        cnt       <= '0;
                        dest_q    <= d_first;
                        dataout   <= make_word('0, SRC, d_first);
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (accept) begin
                        cnt     <= cnt_n;
                        dest_q  <= d_next;
                        dataout <= make_word(cnt_n[3:0], SRC, d_next);
                        if (burst_q != '0 && cnt_n == burst_q) begin
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= ST_DONE;
                        end else if (!enable) begin
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            state     <= ST_IDLE;
                        end else if (gap_q != '0) begin
                            out_valid <= 1'b0;
                            gcnt      <= gap_q;
                            state     <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (!enable) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (gcnt == 4'd1) begin
                        out_valid <= 1'b1;
                        state     <= ST_SEND;
                    end else begin
                        gcnt <= gcnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    if (!enable) begin
                        done  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef NOC_INJ_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sent_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (accept && sent_cnt != 16'hFFFF) begin
                sent_cnt <= sent_cnt + 16'd1;
            end
            if (out_valid && !out_ready && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_noc_inj_gen.sv
// tb_noc_inj_gen: directed bench for noc_inj_gen.
// dut_a: SRC 8 / 16 nodes; dut_b: SRC 3 / 8 nodes.
module tb_noc_inj_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        en_a, rdy_a, vld_a, busy_a, done_a;
    logic [1:0]  mode_a;
    logic [3:0]  fd_a, gap_a;
    logic [7:0]  bl_a;
    logic [19:0] dout_a;

    logic        en_b, rdy_b, vld_b, busy_b, done_b;
    logic [1:0]  mode_b;
    logic [3:0]  fd_b, gap_b;
    logic [7:0]  bl_b;
    logic [19:0] dout_b;

`ifdef NOC_INJ_STATS_EN
    logic [15:0] sent_a, stall_a, sent_b, stall_b;
`endif

    noc_inj_gen #(
        .SRC_ID    (8),
        .NUM_NODES (16),
        .LFSR_SEED (8'hA5)
    ) dut_a (
        .clk        (clk),
        .rst        (rst),
        .enable     (en_a),
        .mode       (mode_a),
        .fixed_dest (fd_a),
        .burst_len  (bl_a),
        .gap        (gap_a),
        .out_ready  (rdy_a),
        .dataout    (dout_a),
        .out_valid  (vld_a),
        .busy       (busy_a),
        .done       (done_a)
`ifdef NOC_INJ_STATS_EN
        ,
        .sent_cnt   (sent_a),
        .stall_cnt  (stall_a)
`endif
    );

    noc_inj_gen #(
        .SRC_ID    (3),
        .NUM_NODES (8),
        .LFSR_SEED (8'hA5)
    ) dut_b (
        .clk        (clk),
        .rst        (rst),
        .enable     (en_b),
        .mode       (mode_b),
        .fixed_dest (fd_b),
        .burst_len  (bl_b),
        .gap        (gap_b),
        .out_ready  (rdy_b),
        .dataout    (dout_b),
        .out_valid  (vld_b),
        .busy       (busy_b),
        .done       (done_b)
`ifdef NOC_INJ_STATS_EN
        ,
        .sent_cnt   (sent_b),
        .stall_cnt  (stall_b)
`endif
    );

    int          cmp_n = 0;
    int          err_n = 0;
    logic [3:0]  rec [20];
    logic [19:0] rw [5];
    logic [19:0] w;
    logic [3:0]  d;
    logic [3:0]  s;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        cmp_n++;
        assert (obs === exp) else begin
            err_n++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_rand(input bit again);
        logic [3:0] rd;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            rd = dout_b[3:0];
            chk("rnd_vld", 32'(vld_b), 32'd1);
            chk("rnd_dest_ok",
                32'(rd != 4'd3 && rd < 4'd8 && dout_b[7:4] == rd &&
                    dout_b[19:16] == k[3:0] && dout_b[15:8] == 8'h30),
                32'd1);
            if (k < 5) chk("rnd_word", 32'(dout_b), 32'(rw[k]));
            if (again) chk("rnd_repeat", 32'(rd), 32'(rec[k]));
            else rec[k] = rd;
            if (k < 19) begin
                repeat (2) begin
                    @(negedge clk);
                    chk("rnd_gap", 32'({vld_b, busy_b}), 32'd1);
                end
            end
        end
        @(negedge clk);
        chk("rnd_done", 32'({done_b, vld_b}), 32'd2);
    endtask

    initial begin
        en_a = 0; mode_a = 0; fd_a = 0; bl_a = 0; gap_a = 0; rdy_a = 1;
        en_b = 0; mode_b = 0; fd_b = 0; bl_b = 0; gap_b = 0; rdy_b = 1;
        rw[0] = 20'h03055;
        rw[1] = 20'h13022;
        rw[2] = 20'h23055;
        rw[3] = 20'h33022;
        rw[4] = 20'h43044;

        repeat (3) @(negedge clk);
        chk("rst_a", 32'({dout_a, vld_a, busy_a, done_a}), 32'd0);
        chk("rst_b", 32'({dout_b, vld_b, busy_b, done_b}), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_a", 32'({vld_a, busy_a}), 32'd0);

        // sweep, 15 packets back to back
        bl_a = 8'd15;
        en_a = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            d = (i < 8) ? i[3:0] : 4'(i + 1);
            w = {i[3:0], 4'h8, 4'h0, d, d};
            chk("sweep_word", 32'({vld_a, busy_a, dout_a}),
                32'({2'b11, w}));
        end
        @(negedge clk);
        chk("sweep_done", 32'({done_a, busy_a, vld_a}), 32'h4);
        en_a = 1'b0;
        @(negedge clk);
        chk("sweep_rearm", 32'(done_a), 32'd0);

        // backpressure on the second packet
        bl_a = 8'd6;
        en_a = 1'b1;
        @(negedge clk);
        chk("bp_w0", 32'(dout_a), 32'h08000);
        @(negedge clk);
        chk("bp_w1", 32'(dout_a), 32'h18011);
        rdy_a = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold", 32'({vld_a, dout_a}), 32'h118011);
        end
        rdy_a = 1'b1;
        for (int i = 2; i < 6; i++) begin
            @(negedge clk);
            w = {i[3:0], 4'h8, 4'h0, i[3:0], i[3:0]};
            chk("bp_word", 32'({vld_a, dout_a}), 32'({1'b1, w}));
        end
        @(negedge clk);
        chk("bp_done", 32'(done_a), 32'd1);
`ifdef NOC_INJ_STATS_EN
        chk("stall_cnt", 32'(stall_a), 32'd5);
        chk("sent_cnt", 32'(sent_a), 32'd21);
`endif
        en_a = 1'b0;
        @(negedge clk);

        // abort with a pending packet, then continuous re-arm
        bl_a = 8'd0;
        rdy_a = 1'b0;
        en_a = 1'b1;
        @(negedge clk);
        chk("abort_pend", 32'({vld_a, dout_a}), 32'h108000);
        en_a = 1'b0;
        @(negedge clk);
        chk("abort_hold", 32'({vld_a, dout_a}), 32'h108000);
        rdy_a = 1'b1;
        @(negedge clk);
        chk("abort_idle", 32'({vld_a, busy_a}), 32'd0);
        en_a = 1'b1;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            s = 4'(i % 15);
            d = (s < 4'd8) ? s : s + 4'd1;
            w = {i[3:0], 4'h8, 4'h0, d, d};
            chk("cont_word", 32'({vld_a, dout_a}), 32'({1'b1, w}));
        end
        en_a = 1'b0;
        @(negedge clk);
        chk("cont_stop", 32'({vld_a, busy_a, done_a}), 32'd0);

        // fixed mode, including the self/out-of-range guard
        mode_b = 2'd1;
        fd_b = 4'd3;
        bl_b = 8'd4;
        en_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("fix_self", 32'(dout_b), 32'({i[3:0], 16'h3044}));
        end
        @(negedge clk);
        chk("fix_done", 32'(done_b), 32'd1);
        en_b = 1'b0;
        @(negedge clk);
        fd_b = 4'd9;
        bl_b = 8'd2;
        en_b = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("fix_range", 32'(dout_b), 32'({i[3:0], 16'h3044}));
        end
        @(negedge clk);
        en_b = 1'b0;
        @(negedge clk);
        fd_b = 4'd5;
        bl_b = 8'd1;
        en_b = 1'b1;
        @(negedge clk);
        chk("fix_legal", 32'(dout_b), 32'h03055);
        @(negedge clk);
        chk("fix1_done", 32'(done_b), 32'd1);
        en_b = 1'b0;
        @(negedge clk);

        // reset mid-burst
        mode_b = 2'd2;
        gap_b = 4'd2;
        bl_b = 8'd20;
        en_b = 1'b1;
        @(negedge clk);
        chk("mid_send", 32'(vld_b), 32'd1);
        #2 rst = 1'b0;
        #1 chk("async_rst", 32'({dout_b, vld_b, busy_b, done_b}), 32'd0);
        en_b = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_idle", 32'({vld_b, busy_b}), 32'd0);
        end

        // random with gap, then repeat after reset
        en_b = 1'b1;
        run_rand(1'b0);
        en_b = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        en_b = 1'b1;
        run_rand(1'b1);
        en_b = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 cmp_n, err_n);
        $finish;
    end

endmodule

// File: doc/noc_inj_gen.md
# noc_inj_gen

Parametrised traffic-injection source for the HSR NoC test harness, one instance per node. It generates 20-bit packets on the fly in three destination modes: all-node sweep, fixed destination, or LFSR-random. Packets leave through a valid/ready handshake with programmable burst length and inter-packet gap. The source re-arms after each burst for repeated injection runs.

## Interface
- `SRC_ID`, 0: node ID placed in the source field; never used as a destination.
- `NUM_NODES`, 16: node count, 2..16; destinations are 0..NUM_NODES-1.
- `LFSR_SEED`, 8'hA5: LFSR reset value; must be nonzero.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `enable`  in  1  level start/run request.
- `mode`  in  2  0 = sweep, 1 = fixed, 2 = random, 3 = reserved (treated as sweep); sampled at burst start.
- `fixed_dest`  in  4  destination for mode 1; sampled at burst start.
- `burst_len`  in  8  packets per burst; 0 = continuous while enable is high; sampled at burst start.
- `gap`  in  4  idle cycles inserted after each accepted packet; sampled at burst start.
- `out_ready`  in  1  downstream accept.
- `dataout`  out  20  packet word.
- `out_valid`  out  1  packet valid.
- `busy`  out  1  high in SEND or GAP.
- `done`  out  1  high in DONE.

## Operation
- Word format:
  - [19:16] seq, the 4-bit count of accepted packets in this burst, modulo 16.
  - [15:12] SRC_ID.
  - [11:8] 4'h0.
  - [7:4] dest.
  - [3:0] dest (payload echo).
- The sweep with seq = 0 reproduces the legacy 0x0S0DD pattern.
- FSM states are IDLE, SEND, GAP and DONE.
  - IDLE: if enable = 1, latch the config, clear seq, load the first destination, go to SEND.
  - SEND: out_valid = 1. On out_valid & out_ready the packet is accepted and the count is incremented.
    - If the count equals burst_len (burst_len != 0), go to DONE.
    - Else if enable = 0, go to IDLE.
    - Else if gap != 0, go to GAP.
    - Else stay in SEND with the next packet.
  - GAP: count down `gap` cycles, then go to SEND. If enable = 0 during GAP, go to IDLE.
  - DONE: hold until enable = 0, then go to IDLE (re-arm).
- Handshake rules:
  - While out_valid = 1 and out_ready = 0, dataout and out_valid hold stable.
  - Deasserting enable never drops a pending valid; the pending packet completes first.
- Sweep order is ascending 0..NUM_NODES-1, skipping SRC_ID. After the last destination it wraps to the lowest non-self destination.
- Fixed mode: if fixed_dest equals SRC_ID or is at least NUM_NODES, every packet uses (SRC_ID+1) mod NUM_NODES.
- Random mode:
  - 8-bit Fibonacci LFSR with taps x^8+x^6+x^5+x^4+1, advancing once per accepted packet.
  - dest = lfsr[3:0] mod NUM_NODES.
  - If dest equals SRC_ID, use (SRC_ID+1) mod NUM_NODES instead.
- The packet counter is 8 bits wide. In continuous mode it wraps freely and seq wraps with it.
- Reset, including mid-burst: all state clears immediately and the LFSR reloads LFSR_SEED.

## Timing
- Reset values: dataout = 0, out_valid = 0, busy = 0, done = 0, state IDLE.
- All outputs are registered.
- enable is sampled high in IDLE at edge N; out_valid is 1 from edge N+1 with the first packet.
- With gap = 0 and out_ready held high, one packet is sent per cycle.
- With gap = G, each accept is followed by G cycles of out_valid = 0.
- done rises the cycle after the final accept and falls the cycle after enable is sampled low.
- The earliest restart is 2 cycles after enable falls: DONE to IDLE, then IDLE to SEND.

## Configuration
- `NOC_INJ_STATS_EN` defined:
  - Adds `sent_cnt` (out, 16 bits), counting total accepted packets; saturates at 16'hFFFF.
  - Adds `stall_cnt` (out, 16 bits), counting cycles with out_valid & !out_ready; saturates at 16'hFFFF.
  - Both counters reset to 0 and are never cleared by re-arm.
- `NOC_INJ_STATS_EN` undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package `noc_inj_pkg` holds:
  - the word field positions and widths;
  - the mode encodings `MODE_SWEEP`, `MODE_FIXED`, `MODE_RANDOM`;
  - the FSM state type;
  - `NODE_W = 4`.
- One sub-module, `noc_inj_lfsr`, containing the seed parameter, an advance strobe and an 8-bit state output.
- Destination selection (sweep, fixed, random, self-skip) stays inline in `noc_inj_gen`.

## Test plan
- Sweep: SRC_ID = 8, NUM_NODES = 16, mode 0, burst_len = 15, gap = 0, out_ready = 1 → fifteen words, 0x08000, 0x18011 … 0x7807​7, then 0x88099 … 0xE80FF; done rises the next cycle.
- Backpressure: out_ready = 0 for 5 cycles mid-burst → dataout and out_valid are stable for 5 cycles and no packet is skipped; with stats enabled, stall_cnt = 5.
- Fixed-mode guard: SRC_ID = 3, mode 1, fixed_dest = 3, burst_len = 4 → all four words have dest 4; fixed_dest = 9 with NUM_NODES = 8 → dest 4.
- Random and gap: mode 2, gap = 2, burst_len = 20 → no dest equals SRC_ID, all dest < NUM_NODES, and two idle cycles follow each accept; after reset the sequence repeats identically.
- Abort and re-arm: enable drops while valid is pending with out_ready = 0, then out_ready rises → the packet is accepted, then the block goes to IDLE; enable raised again → seq restarts at 0.
- Reset mid-burst: rst pulled low during SEND → out_valid = 0 immediately and all outputs reset; after release, idle until enable.
